// File: rtl/control_register_bank.sv
// control_register_bank: CPU-facing control register file for the video
// pipeline. CPU writes go to a shadow copy and reach the active copy (which
// drives the renderer) only on a frame_sync pulse, so controls never change
// mid-frame. One register is a read-only sticky status register that is
// cleared by reading it. Setting IMMEDIATE bypasses the double buffering.
// NUM_REGS must not exceed 2**ADDR_WIDTH.
module control_register_bank #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 3,
  parameter int                    NUM_REGS    = 8,
  parameter int                    STATUS_REG  = NUM_REGS - 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter bit                    IMMEDIATE   = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          write_addr,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic                           write_enable,
  input  logic [ADDR_WIDTH-1:0]          read_addr,
  input  logic                           read_enable,
  output logic [DATA_WIDTH-1:0]          read_data,
  input  logic                           frame_sync,
  input  logic [DATA_WIDTH-1:0]          status_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
  output logic                           commit_pending
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // What a CPU read of each address would return: shadow value for control
  // registers, the live sticky value for the status register, zero for holes.
  logic [DEPTH-1:0][DATA_WIDTH-1:0] read_view;
  logic [NUM_REGS-1:0]              dirty_flags;

  logic [DATA_WIDTH-1:0] sticky_reg;
  logic [DATA_WIDTH-1:0] sticky_next;
  logic [DATA_WIDTH-1:0] clear_mask;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi = gi + 1) begin : gen_reg
      if (gi == STATUS_REG) begin : gen_status
        assign read_view[gi]                            = sticky_reg;
        assign ctrl_out[gi*DATA_WIDTH +: DATA_WIDTH]    = sticky_reg;
        assign dirty_flags[gi]                          = 1'b0;
      end else if (gi < NUM_REGS) begin : gen_ctrl
        logic [DATA_WIDTH-1:0] shadow_reg;
        logic [DATA_WIDTH-1:0] active_reg;
        logic                  dirty_reg;
        logic                  write_hit;

        assign write_hit = write_enable && (write_addr == ADDR_WIDTH'(gi));

        // Shadow/active/dirty update. A commit in the same cycle as a write
        // moves the pre-write shadow, and the new write stays dirty for the
        // next frame.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            shadow_reg <= RESET_VALUE;
            active_reg <= RESET_VALUE;
            dirty_reg  <= 1'b0;
          end else if (IMMEDIATE) begin
            if (write_hit) begin
              shadow_reg <= write_data;
              active_reg <= write_data;
            end
          end else begin
            if (frame_sync && dirty_reg) begin
              active_reg <= shadow_reg;
            end
            if (write_hit) begin
              shadow_reg <= write_data;
              dirty_reg  <= 1'b1;
            end else if (frame_sync) begin
              dirty_reg  <= 1'b0;
            end
          end
        end

        assign read_view[gi]                         = shadow_reg;
        assign ctrl_out[gi*DATA_WIDTH +: DATA_WIDTH] = active_reg;
        assign dirty_flags[gi]                       = dirty_reg;
      end else begin : gen_hole
        assign read_view[gi] = '0;
      end
    end
  endgenerate

  // Sticky status next value: reading the status register clears the bits it
  // returned, but a set request in the same cycle wins.
  always_comb begin
    clear_mask = '0;
    if (read_enable && (read_addr == ADDR_WIDTH'(STATUS_REG))) begin
      clear_mask = sticky_reg;
    end
    sticky_next = (sticky_reg & ~clear_mask) | status_set;
  end

  // Sticky status register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_reg <= '0;
    end else begin
      sticky_reg <= sticky_next;
    end
  end

  // Registered read port; holds its last value while read_enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
    end else if (read_enable) begin
      read_data <= read_view[read_addr];
    end
  end

  assign commit_pending = |dirty_flags;

endmodule

// File: tb/tb_control_register_bank.sv
// Testbench for control_register_bank: a deferred-commit instance and an
// IMMEDIATE instance share stimulus. The driver updates a behavioural model
// and queues the expected post-edge outputs; a monitor pops one entry per
// clock edge and compares at the following falling edge.
module tb_control_register_bank;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int N  = 6;
  localparam int S  = N - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          write_enable = 1'b0;
  logic [AW-1:0] read_addr = '0;
  logic          read_enable = 1'b0;
  logic          frame_sync = 1'b0;
  logic [DW-1:0] status_set = '0;

  logic [DW-1:0]   read_data, read_data_imm;
  logic [N*DW-1:0] ctrl_out, ctrl_out_imm;
  logic            commit_pending, commit_pending_imm;

  control_register_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(N), .STATUS_REG(S),
    .RESET_VALUE('0), .IMMEDIATE(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .write_addr(write_addr), .write_data(write_data),
    .write_enable(write_enable), .read_addr(read_addr), .read_enable(read_enable),
    .read_data(read_data), .frame_sync(frame_sync), .status_set(status_set),
    .ctrl_out(ctrl_out), .commit_pending(commit_pending)
  );

  control_register_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(N), .STATUS_REG(S),
    .RESET_VALUE('0), .IMMEDIATE(1'b1)
  ) dut_imm (
    .clk(clk), .reset(reset), .write_addr(write_addr), .write_data(write_data),
    .write_enable(write_enable), .read_addr(read_addr), .read_enable(read_enable),
    .read_data(read_data_imm), .frame_sync(frame_sync), .status_set(status_set),
    .ctrl_out(ctrl_out_imm), .commit_pending(commit_pending_imm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*DW-1:0] ctrl;
    logic [N*DW-1:0] ctrl_imm;
    logic            pend;
    logic [DW-1:0]   rd;
  } exp_t;

  exp_t q[$];

  int n_vec  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [DW-1:0] sh_m [N];
  logic [DW-1:0] ac_m [N];
  logic [DW-1:0] ai_m [N];
  logic          dt_m [N];
  logic [DW-1:0] st_m;
  logic [DW-1:0] rd_m;

  task automatic check(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sh_m[i] = '0; ac_m[i] = '0; ai_m[i] = '0; dt_m[i] = 1'b0;
    end
    st_m = '0;
    rd_m = '0;
  endtask

  // Apply one cycle of stimulus, advance the model, queue the expectation.
  task automatic step(input logic we, input int wa, input logic [DW-1:0] wd,
                      input logic re, input int ra, input logic fs,
                      input logic [DW-1:0] ss);
    exp_t          e;
    logic [DW-1:0] clr;
    logic          any_dirty;
    write_enable = we; write_addr = AW'(wa); write_data = wd;
    read_enable  = re; read_addr  = AW'(ra);
    frame_sync   = fs; status_set = ss;

    if (re) begin
      if (ra >= N)      rd_m = '0;
      else if (ra == S) rd_m = st_m;
      else              rd_m = sh_m[ra];
    end
    if (fs) begin
      for (int i = 0; i < N; i++) begin
        if (dt_m[i]) begin
          ac_m[i] = sh_m[i];
          dt_m[i] = 1'b0;
        end
      end
    end
    if (we && wa < N && wa != S) begin
      sh_m[wa] = wd;
      ai_m[wa] = wd;
      dt_m[wa] = 1'b1;
    end
    clr  = (re && ra == S) ? st_m : '0;
    st_m = (st_m & ~clr) | ss;

    any_dirty = 1'b0;
    for (int i = 0; i < N; i++) begin
      any_dirty = any_dirty | dt_m[i];
      e.ctrl[i*DW +: DW]     = (i == S) ? st_m : ac_m[i];
      e.ctrl_imm[i*DW +: DW] = (i == S) ? st_m : ai_m[i];
    end
    e.pend = any_dirty;
    e.rd   = rd_m;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0; read_enable = 1'b0; frame_sync = 1'b0;
    status_set = '0; write_addr = '0; read_addr = '0; write_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctrl_out"},           ctrl_out, '0);
    check({tag, " read_data"},          {{(N*DW-DW){1'b0}}, read_data}, '0);
    check({tag, " commit_pending"},     {{(N*DW-1){1'b0}}, commit_pending}, '0);
    check({tag, " ctrl_out_imm"},       ctrl_out_imm, '0);
    check({tag, " read_data_imm"},      {{(N*DW-DW){1'b0}}, read_data_imm}, '0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic async_reset();
    idle_inputs();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: one expectation per clock edge, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        @(negedge clk);
        check("ctrl_out",       ctrl_out, e.ctrl);
        check("ctrl_out_imm",   ctrl_out_imm, e.ctrl_imm);
        check("commit_pending", {{(N*DW-1){1'b0}}, commit_pending}, {{(N*DW-1){1'b0}}, e.pend});
        check("commit_pending_imm", {{(N*DW-1){1'b0}}, commit_pending_imm}, '0);
        check("read_data",      {{(N*DW-DW){1'b0}}, read_data}, {{(N*DW-DW){1'b0}}, e.rd});
        check("read_data_imm",  {{(N*DW-DW){1'b0}}, read_data_imm}, {{(N*DW-DW){1'b0}}, e.rd});
        $display("vec %0d: ctrl=%h ctrl_imm=%h pend=%0b rd=%h", n_vec, ctrl_out, ctrl_out_imm, commit_pending, read_data);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Read every address after reset
    for (int a = 0; a < 2 ** AW; a++) step(0, 0, 8'h00, 1, a, 0, 8'h00);

    // Deferred commit of reg1
    step(1, 1, 8'h5A, 0, 0, 0, 8'h00);
    step(0, 0, 8'h00, 1, 1, 0, 8'h00);
    step(0, 0, 8'h00, 0, 0, 1, 8'h00);
    step(0, 0, 8'h00, 0, 0, 0, 8'h00);

    // Write coinciding with commit
    step(1, 2, 8'h11, 0, 0, 0, 8'h00);
    step(1, 2, 8'h22, 0, 0, 1, 8'h00);
    step(0, 0, 8'h00, 1, 2, 0, 8'h00);
    step(0, 0, 8'h00, 0, 0, 1, 8'h00);

    // Read and write the same address in one cycle returns the old value
    step(1, 3, 8'hAA, 1, 3, 0, 8'h00);
    step(0, 0, 8'h00, 1, 3, 0, 8'h00);

    // Sticky status: set, read, read again; set concurrent with read
    step(0, 0, 8'h00, 0, 0, 0, 8'h81);
    step(0, 0, 8'h00, 1, S, 0, 8'h00);
    step(0, 0, 8'h00, 1, S, 0, 8'h00);
    step(0, 0, 8'h00, 0, 0, 0, 8'h02);
    step(0, 0, 8'h00, 1, S, 0, 8'h01);
    step(0, 0, 8'h00, 1, S, 0, 8'h00);

    // Ignored writes: beyond NUM_REGS and to the status register
    step(1, 6, 8'hFF, 0, 0, 0, 8'h00);
    step(1, S, 8'hFF, 0, 0, 0, 8'h00);
    step(1, 7, 8'hFF, 1, 7, 0, 8'h00);
    step(0, 0, 8'h00, 1, S, 1, 8'h00);
    step(0, 0, 8'h00, 1, 6, 0, 8'h00);

    // Reset mid-frame discards a pending write
    step(1, 0, 8'h33, 0, 0, 0, 8'h00);
    async_reset();
    step(0, 0, 8'h00, 0, 0, 1, 8'h00);
    step(0, 0, 8'h00, 1, 0, 0, 8'h00);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0),
           8'($urandom & $urandom & $urandom));
    end

    idle_inputs();
    @(negedge clk);
    #1;
    check("queue_drained", (N*DW)'(q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/control_register_bank.md
# control_register_bank

Parametrised CPU-facing control register file for the video pipeline: the successor to the 8 x 8-bit control register block. CPU writes land in a shadow copy and are committed to the active copy only at a frame-sync pulse, so renderer controls never change mid-frame. One register is a read-only sticky status register that clears on read. The active copy drives the renderer through a flattened bus.

## Interface
Parameters:
- DATA_WIDTH, 8, register width in bits.
- ADDR_WIDTH, 3, address width.
- NUM_REGS, 8, number of implemented registers; requires NUM_REGS <= 2**ADDR_WIDTH.
- STATUS_REG, NUM_REGS-1, index of the read-only sticky status register.
- RESET_VALUE, 0, reset value of every shadow and active register.
- IMMEDIATE, 0, 1 = writes also update the active copy in the same cycle (bypass double-buffering).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- write_addr  in  ADDR_WIDTH  CPU write address.
- write_data  in  DATA_WIDTH  CPU write data.
- write_enable  in  1  write strobe, one write per cycle.
- read_addr  in  ADDR_WIDTH  CPU read address.
- read_enable  in  1  read strobe; needed for status read-to-clear.
- read_data  out  DATA_WIDTH  registered read result.
- frame_sync  in  1  one-cycle commit pulse (start of vblank).
- status_set  in  DATA_WIDTH  per-bit set requests into the status register.
- ctrl_out  out  NUM_REGS*DATA_WIDTH  active registers, register i at bits [i*DATA_WIDTH +: DATA_WIDTH]; the STATUS_REG slice is the live status.
- commit_pending  out  1  high while any shadow register is dirty.

## Operation
- Storage: shadow[i], active[i], dirty[i] for each non-status register, plus status.
- Write (write_enable=1, addr < NUM_REGS, addr != STATUS_REG): shadow[addr] <= write_data; dirty[addr] <= 1. Writes to STATUS_REG or to addr >= NUM_REGS are ignored.
- Commit (frame_sync=1): for every i with dirty[i]=1, active[i] <= shadow[i] and dirty[i] <= 0.
- Write and commit in the same cycle:
  - The commit copies the pre-write shadow value.
  - The written register ends the cycle with the new shadow value and dirty=1, so it commits at the next frame_sync.
- IMMEDIATE=1: a write updates shadow and active together; dirty never sets; frame_sync has no effect.
- Read: read_data returns:
  - shadow[addr] for a control register (the CPU reads back what it wrote);
  - status for STATUS_REG;
  - 0 for addr >= NUM_REGS.
- Status: each cycle, status <= (status & ~clear_mask) | status_set.
  - clear_mask = status when read_enable=1 and read_addr=STATUS_REG; otherwise 0.
  - Set wins over clear for the same bit in the same cycle.
  - The read returns the value before clearing.
- commit_pending = OR of all dirty bits.

## Timing
- Reset (asynchronous): shadow, active = RESET_VALUE; dirty = 0; status = 0; read_data = 0; commit_pending = 0.
- Write to shadow: 1 cycle; read-back of that address is valid from the next read.
- Read latency: 1 cycle; read_data holds its value when read_enable=0.
- Read and write to the same address in the same cycle: read returns the old shadow value.
- ctrl_out updates on the clk edge where frame_sync is sampled high (0-cycle latency after the edge). In IMMEDIATE mode it updates on the write edge.
- commit_pending:
  - rises the cycle after the first write;
  - falls the cycle after a frame_sync that found no concurrent write.
- Reset asserted mid-frame discards all pending writes.

## Test plan
- Reset:
  - Assert reset for 2 cycles -> ctrl_out = 0, read_data = 0, commit_pending = 0.
  - Read all addresses -> 0.
- Deferred commit:
  - Write reg1 = 0x5A -> read reg1 returns 0x5A next cycle, ctrl_out[15:8] stays 0x00, commit_pending = 1.
  - Pulse frame_sync -> ctrl_out[15:8] = 0x5A and commit_pending = 0 after the edge.
- Simultaneous write and commit:
  - Write reg2 = 0x11, then reg2 = 0x22 in the same cycle as frame_sync -> ctrl_out[23:16] = 0x11, commit_pending = 1.
  - Next frame_sync -> ctrl_out[23:16] = 0x22.
- Sticky status:
  - Pulse status_set = 0x81 -> read STATUS_REG returns 0x81; a second read returns 0x00.
  - Read in the same cycle as status_set = 0x01 -> returns the old value; bit 0 remains set.
- Illegal writes (NUM_REGS = 6, ADDR_WIDTH = 3):
  - Write addr 6 = 0xFF and write STATUS_REG = 0xFF -> no register changes; read addr 7 returns 0.
- Async reset mid-operation:
  - Write reg0 = 0x33, assert reset between clock edges before frame_sync -> outputs clear immediately.
  - After release, frame_sync -> ctrl_out[7:0] = 0x00.
